// File: rtl/fb_arb_pkg.sv
// Shared encodings and default parameters for the framebuffer arbiter.
package fb_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_ISSUE = 2'd2,
    ST_ACK   = 2'd3
  } state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

  localparam int DEF_WIDTH        = 32;
  localparam int DEF_STARVE_LIMIT = 4;
  localparam int DEF_TIMEOUT      = 1023;

endpackage

// File: rtl/fb_arb_pick.sv
// Read-priority grant decision with a write-starvation streak counter.
module fb_arb_pick
  import fb_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic clk,
  input  logic rst,
  input  logic i_rd_req,
  input  logic i_wr_req,
  input  logic i_grant_en,
  output op_t  o_op
);

  localparam int SW = $clog2(STARVE_LIMIT + 2);
  localparam logic [SW-1:0] LIM = SW'(STARVE_LIMIT);

  logic [SW-1:0] r_streak;
  logic          w_starved;

  assign w_starved = (r_streak == LIM);
  assign o_op      = (i_wr_req && (!i_rd_req || w_starved)) ? OP_WR : OP_RD;

  // Streak only grows while a write is actually being passed over.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_streak <= '0;
    end else if (i_grant_en) begin
      if (o_op == OP_RD && i_wr_req) begin
        if (!w_starved) r_streak <= r_streak + 1'b1;
      end else begin
        r_streak <= '0;
      end
    end
  end

endmodule

// File: rtl/fb_arbiter.sv
// Framebuffer arbiter: one outstanding read/write transaction through
// IDLE -> SETUP -> ISSUE -> ACK, with an ISSUE-phase timeout.
module fb_arbiter
  import fb_arb_pkg::*;
#(
  parameter int WIDTH        = DEF_WIDTH,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
  parameter int TIMEOUT      = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rd_req,
  input  logic [15:0]      rd_x,
  input  logic [15:0]      rd_y,
  output logic             rd_ack,
  output logic [WIDTH-1:0] rd_rgb,
  input  logic             wr_req,
  input  logic [15:0]      wr_x,
  input  logic [15:0]      wr_y,
  input  logic [WIDTH-1:0] wr_rgb,
  output logic             wr_ack,
  output logic             fb_do_read,
  output logic             fb_do_write,
  output logic [15:0]      fb_pix_x,
  output logic [15:0]      fb_pix_y,
  output logic [WIDTH-1:0] fb_write_rgb,
  input  logic [WIDTH-1:0] fb_read_rgb,
  input  logic             fb_done,
  output logic             timeout_err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t           r_state, w_next;
  op_t              r_op, w_op;
  logic [15:0]      r_x, r_y;
  logic [WIDTH-1:0] r_wrgb, r_rgb;
  logic [CW-1:0]    r_cnt;
  logic             r_tout, w_tout, w_grant;

  assign w_grant = (r_state == ST_IDLE) && (rd_req || wr_req);

  fb_arb_pick #(.STARVE_LIMIT(STARVE_LIMIT)) u_pick (
    .clk        (clk),
    .rst        (rst),
    .i_rd_req   (rd_req),
    .i_wr_req   (wr_req),
    .i_grant_en (w_grant),
    .o_op       (w_op)
  );

  always_comb begin
    w_next = r_state;
    w_tout = 1'b0;
    case (r_state)
      ST_IDLE:  if (rd_req || wr_req) w_next = ST_SETUP;
      ST_SETUP: w_next = ST_ISSUE;
      ST_ISSUE: begin
        if (fb_done) begin
          w_next = ST_ACK;
        end else if (r_cnt == CNT_LAST) begin
          w_next = ST_ACK;
          w_tout = 1'b1;
        end
      end
      ST_ACK:   w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_op    <= OP_RD;
      r_x     <= '0;
      r_y     <= '0;
      r_wrgb  <= '0;
      r_rgb   <= '0;
      r_cnt   <= '0;
      r_tout  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_tout  <= w_tout;
      r_cnt   <= (r_state == ST_ISSUE) ? r_cnt + 1'b1 : '0;
      if (w_grant) begin
        r_op   <= w_op;
        r_x    <= (w_op == OP_WR) ? wr_x : rd_x;
        r_y    <= (w_op == OP_WR) ? wr_y : rd_y;
        r_wrgb <= wr_rgb;
      end
      // An aborted read returns zero rather than stale data.
      if (r_state == ST_ISSUE && r_op == OP_RD) begin
        if (fb_done)     r_rgb <= fb_read_rgb;
        else if (w_tout) r_rgb <= '0;
      end
    end
  end

  assign fb_do_read   = (r_state == ST_ISSUE) && (r_op == OP_RD);
  assign fb_do_write  = (r_state == ST_ISSUE) && (r_op == OP_WR);
  assign rd_ack       = (r_state == ST_ACK) && (r_op == OP_RD);
  assign wr_ack       = (r_state == ST_ACK) && (r_op == OP_WR);
  assign timeout_err  = r_tout;
  assign fb_pix_x     = r_x;
  assign fb_pix_y     = r_y;
  assign fb_write_rgb = r_wrgb;
  assign rd_rgb       = r_rgb;

endmodule

// File: tb/tb_fb_arbiter.sv
// Directed self-checking bench for fb_arbiter.
module tb_fb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_req, wr_req, fb_done;
  logic [15:0] rd_x, rd_y, wr_x, wr_y;
  logic [31:0] wr_rgb, fb_read_rgb;
  logic        rd_ack, wr_ack, fb_do_read, fb_do_write, timeout_err;
  logic [31:0] rd_rgb, fb_write_rgb;
  logic [15:0] fb_pix_x, fb_pix_y;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fb_arbiter dut (
    .clk(clk), .rst(rst),
    .rd_req(rd_req), .rd_x(rd_x), .rd_y(rd_y), .rd_ack(rd_ack), .rd_rgb(rd_rgb),
    .wr_req(wr_req), .wr_x(wr_x), .wr_y(wr_y), .wr_rgb(wr_rgb), .wr_ack(wr_ack),
    .fb_do_read(fb_do_read), .fb_do_write(fb_do_write),
    .fb_pix_x(fb_pix_x), .fb_pix_y(fb_pix_y), .fb_write_rgb(fb_write_rgb),
    .fb_read_rgb(fb_read_rgb), .fb_done(fb_done), .timeout_err(timeout_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b0; rd_req = 1'b0; wr_req = 1'b0; fb_done = 1'b0;
    rd_x = '0; rd_y = '0; wr_x = '0; wr_y = '0; wr_rgb = '0; fb_read_rgb = '0;
    tick(); tick();
    chk("rst_acks",  32'({rd_ack, wr_ack, timeout_err}), 32'd0);
    chk("rst_fbdo",  32'({fb_do_read, fb_do_write}), 32'd0);
    chk("rst_pix",   32'({fb_pix_x, fb_pix_y}), 32'd0);
    chk("rst_rgb",   rd_rgb | fb_write_rgb, 32'd0);
    rst = 1'b1;
    tick();

    // Basic read with three ISSUE cycles
    rd_req = 1'b1; rd_x = 16'd10; rd_y = 16'd5;
    tick();
    chk("rd_setup_pix", 32'({fb_pix_x, fb_pix_y}), {16'd10, 16'd5});
    chk("rd_setup_do",  32'(fb_do_read), 32'd0);
    tick();
    chk("rd_issue1", 32'({fb_do_read, fb_do_write}), 32'b10);
    tick();
    chk("rd_issue2", 32'(fb_do_read), 32'd1);
    fb_read_rgb = 32'h00FF00FF;
    tick();
    fb_done = 1'b1;
    chk("rd_issue3", 32'(fb_do_read), 32'd1);
    tick();
    chk("rd_ack",     32'({rd_ack, wr_ack, fb_do_read}), 32'b100);
    chk("rd_ack_rgb", rd_rgb, 32'h00FF00FF);
    rd_req = 1'b0; fb_done = 1'b0; fb_read_rgb = 32'hCAFEF00D;
    tick();
    chk("rd_ack_pulse", 32'(rd_ack), 32'd0);
    chk("rd_rgb_hold",  rd_rgb, 32'h00FF00FF);

    // Both requesters held: four reads then one write, repeating
    rd_req = 1'b1; wr_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      tick();
      chk($sformatf("arb_do_%0d", i), 32'({fb_do_write, fb_do_read}),
          (i % 5 == 4) ? 32'b10 : 32'b01);
      fb_done = 1'b1;
      tick();
      chk($sformatf("arb_ack_%0d", i), 32'({wr_ack, rd_ack}),
          (i % 5 == 4) ? 32'b10 : 32'b01);
      fb_done = 1'b0;
      tick();
    end
    rd_req = 1'b0; wr_req = 1'b0;
    tick();

    // Write only
    wr_req = 1'b1; wr_x = 16'd639; wr_y = 16'd479; wr_rgb = 32'h12345678;
    tick();
    chk("wr_setup_pix", 32'({fb_pix_x, fb_pix_y}), {16'd639, 16'd479});
    chk("wr_setup_rgb", fb_write_rgb, 32'h12345678);
    tick();
    chk("wr_issue", 32'({fb_do_write, fb_do_read}), 32'b10);
    fb_done = 1'b1;
    tick();
    chk("wr_ack", 32'({wr_ack, rd_ack}), 32'b10);
    wr_req = 1'b0; fb_done = 1'b0;
    tick();
    chk("wr_idle", 32'({wr_ack, rd_ack, fb_do_write}), 32'd0);

    // Read timeout: fb_done never comes
    rd_req = 1'b1; rd_x = 16'd1; rd_y = 16'd2; fb_read_rgb = 32'hDEADBEEF;
    tick();
    tick();
    chk("to_issue1", 32'(fb_do_read), 32'd1);
    repeat (1022) tick();
    chk("to_issue1023", 32'({fb_do_read, timeout_err, rd_ack}), 32'b100);
    tick();
    chk("to_ack", 32'({fb_do_read, timeout_err, rd_ack}), 32'b011);
    chk("to_rgb", rd_rgb, 32'd0);
    rd_req = 1'b0;
    tick();
    chk("to_pulse", 32'({timeout_err, rd_ack}), 32'd0);

    // Reset in the second ISSUE cycle of a write
    wr_req = 1'b1; wr_x = 16'd7; wr_y = 16'd8; wr_rgb = 32'hA5A5A5A5;
    tick(); tick(); tick();
    chk("rw_issue2", 32'(fb_do_write), 32'd1);
    rst = 1'b0;
    tick();
    chk("rw_reset", 32'({fb_do_write, wr_ack, rd_ack}), 32'd0);
    chk("rw_pix",   32'(fb_pix_x), 32'd0);
    rst = 1'b1;
    tick();
    chk("rw_regrant", 32'({fb_pix_x, fb_pix_y}), {16'd7, 16'd8});
    tick();
    chk("rw_issue", 32'(fb_do_write), 32'd1);
    fb_done = 1'b1;
    tick();
    chk("rw_ack", 32'({wr_ack, rd_ack}), 32'b10);
    wr_req = 1'b0; fb_done = 1'b0;
    tick();

    // Stray fb_done in IDLE, then coordinate change mid-ISSUE
    fb_done = 1'b1;
    tick();
    chk("stray_done", 32'({rd_ack, wr_ack, fb_do_read, fb_do_write}), 32'd0);
    fb_done = 1'b0;
    rd_req = 1'b1; rd_x = 16'd100; rd_y = 16'd200;
    tick(); tick();
    rd_x = 16'd300;
    tick();
    chk("mid_pix", 32'(fb_pix_x), 32'd100);
    chk("mid_noack", 32'(rd_ack), 32'd0);
    fb_read_rgb = 32'h0BADF00D; fb_done = 1'b1;
    tick();
    chk("mid_ack", 32'(rd_ack), 32'd1);
    chk("mid_rgb", rd_rgb, 32'h0BADF00D);
    rd_req = 1'b0; fb_done = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fb_arbiter.md
FB_ARBITER -- requirements
Module: fb_arbiter

Interface
REQ-001 Parameter WIDTH, default 32, pixel/data width.
REQ-002 Parameter STARVE_LIMIT, default 4, maximum consecutive read grants while a write is pending.
REQ-003 Parameter TIMEOUT, default 1023, maximum ISSUE cycles before abort.
REQ-004 Ports SHALL be, one per line: name, direction, width, meaning.
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- rd_req  in  1  scanout read request, held until rd_ack.
- rd_x, rd_y  in  16 each  read pixel coordinates, stable while rd_req.
- rd_ack  out  1  one-cycle pulse, read complete.
- rd_rgb  out  WIDTH  read pixel, valid when rd_ack.
- wr_req  in  1  compute write request, held until wr_ack.
- wr_x, wr_y  in  16 each  write pixel coordinates.
- wr_rgb  in  WIDTH  write pixel value.
- wr_ack  out  1  one-cycle pulse, write complete.
- fb_do_read, fb_do_write  out  1 each  framebuffer commands, level.
- fb_pix_x, fb_pix_y  out  16 each  framebuffer coordinates.
- fb_write_rgb  out  WIDTH  framebuffer write data.
- fb_read_rgb  in  WIDTH  framebuffer read data.
- fb_done  in  1  framebuffer completion.
- timeout_err  out  1  one-cycle pulse on aborted transaction.

Function
REQ-005 FSM states SHALL be IDLE, SETUP, ISSUE, ACK; at most one framebuffer transaction outstanding.
REQ-006 IDLE, no request: stay IDLE.
REQ-007 IDLE, any request: arbitrate, latch op, coordinates and wr_rgb into internal registers, go to SETUP.
REQ-008 Arbitration: read wins over write, except write wins when wr_req=1 and streak==STARVE_LIMIT.
REQ-009 Streak counter: +1 on a read grant with wr_req=1; cleared on a write grant or on a read grant with wr_req=0; saturates at STARVE_LIMIT.
REQ-010 SETUP (1 cycle): drive latched fb_pix_x/fb_pix_y/fb_write_rgb, fb_do_* low, go to ISSUE; this gives the downstream registered address one cycle to settle.
REQ-011 ISSUE: hold exactly one of fb_do_read/fb_do_write high, matching the latched op, until fb_done=1.
REQ-012 ISSUE with fb_done=1: for a read, capture fb_read_rgb into rd_rgb; go to ACK.
REQ-013 ACK (1 cycle): fb_do_* low; pulse rd_ack or wr_ack for the latched op; go to IDLE.
REQ-014 Requests are not sampled in SETUP, ISSUE or ACK; a requester may drop req in the ACK cycle.
REQ-015 Minimum transaction latency SHALL be 4 cycles (IDLE grant to ack) with fb_done on the first ISSUE cycle.
REQ-016 ISSUE cycle counter: reaching TIMEOUT without fb_done SHALL drop fb_do_*, pulse timeout_err, and go to ACK; a read ack then carries rd_rgb=0.
REQ-017 fb_done outside ISSUE SHALL be ignored.
REQ-018 rd_rgb SHALL hold its value between reads.
REQ-019 Coordinate and data changes on rd_*/wr_* after grant SHALL NOT affect the transaction in flight.

Reset
REQ-020 With rst=0 at a clock edge, the following SHALL be cleared: state=IDLE, streak, timeout counter, all outputs (acks, fb_do_*, fb_pix_*, fb_write_rgb, rd_rgb, timeout_err).
REQ-021 Reset during ISSUE SHALL deassert fb_do_* on that edge with no ack issued; the requester re-requests.

Structure
REQ-022 Package fb_arb_pkg SHALL hold the state encoding (2-bit), the op encoding (OP_RD, OP_WR) and the default parameter constants.
REQ-023 Sub-module fb_arb_pick SHALL contain the grant decision and the streak counter; the top holds FSM, latches and timeout.

Verification
REQ-024 rd_req=1 (x=10, y=5); fb_done after 3 ISSUE cycles with fb_read_rgb=0x00FF00FF -> fb_pix=(10,5) one cycle before fb_do_read; rd_ack pulse with rd_rgb=0x00FF00FF.
REQ-025 rd_req and wr_req both held continuously -> grant order R,R,R,R,W,R,R,R,R,W.
REQ-026 wr_req only (x=639, y=479, rgb=0x12345678) -> fb_do_write with those values; wr_ack after fb_done; rd_ack stays 0.
REQ-027 Read with fb_done never asserted -> fb_do_read drops after 1023 ISSUE cycles; timeout_err and rd_ack pulse together with rd_rgb=0.
REQ-028 rst=0 in the 2nd ISSUE cycle of a write -> next edge: fb_do_write=0, state IDLE, no wr_ack; after release, the held wr_req completes normally.
REQ-029 Stray fb_done in IDLE, plus rd_x changed mid-ISSUE -> no ack generated; fb_pix_x keeps the latched value.
